// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory copy requester and its buffer.
package mem_pkg;

  typedef enum logic [1:0] {
    Idle,
    Run,
    Finish
  } copy_state_e;

  // Counters need one extra bit so a full-memory copy (len = 2^addr_width) fits.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PtrW:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (PtrW + 1)'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    dout     = mem_q[rd_ptr_q];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_copy_requester.sv
// Copies len words from src_base to dst_base through one memory requester port,
// buffering read responses so every issued read has a reserved slot.
module mem_copy_requester
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_aready,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready
);

  localparam int unsigned CntW = cnt_width(ADDR_WIDTH);
  localparam int unsigned FcW  = $clog2(FIFO_DEPTH) + 1;

  copy_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CntW-1:0]       len_q, len_d;
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [FcW-1:0]        outst_q, outst_d;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic [FcW-1:0]        fifo_count;
  logic [FcW:0]          in_flight;
  logic                  r_hs, w_hs, rsp_push;

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rsp_push),
    .din  (r_data),
    .pop  (w_hs),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // in_flight only grows on a read handshake, so r_avalid/r_addr hold until accepted.
  always_comb begin
    in_flight = {1'b0, outst_q} + {1'b0, fifo_count};
    busy      = (state_q != Idle);
    done      = (state_q == Finish);
    r_avalid  = (state_q == Run) && (rd_cnt_q < len_q) && !fifo_full &&
                (in_flight < (FcW + 1)'(FIFO_DEPTH));
    r_addr    = src_q + rd_cnt_q[ADDR_WIDTH-1:0];
    w_valid   = (state_q == Run) && !fifo_empty;
    w_addr    = dst_q + wr_cnt_q[ADDR_WIDTH-1:0];
    w_data    = w_valid ? fifo_dout : '0;
    r_hs      = r_avalid && r_aready;
    w_hs      = w_valid && w_ready;
    rsp_push  = r_dvalid && (state_q != Idle);
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    outst_d  = outst_q;
    unique case (state_q)
      Idle: begin
        if (start) begin
          src_d    = src_base;
          dst_d    = dst_base;
          len_d    = len;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          outst_d  = '0;
          state_d  = (len == '0) ? Finish : Run;
        end
      end
      Run: begin
        if (r_hs) rd_cnt_d = rd_cnt_q + CntW'(1);
        if (w_hs) begin
          wr_cnt_d = wr_cnt_q + CntW'(1);
          if (wr_cnt_d == len_q) state_d = Finish;
        end
        if (r_hs && !rsp_push) begin
          outst_d = outst_q + FcW'(1);
        end else if (!r_hs && rsp_push) begin
          outst_d = outst_q - FcW'(1);
        end
      end
      Finish: state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= Idle;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      outst_q  <= outst_d;
    end
  end

endmodule

// File: doc/mem_copy_requester.md
MEM_COPY_REQUESTER -- requirements
Module: mem_copy_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory word width.
REQ-002 Parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 Parameter FIFO_DEPTH, default 4, read-data buffer entries; SHALL be a power of 2 and at least 2.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a copy.
REQ-007 src_base  in  ADDR_WIDTH  first source address.
REQ-008 dst_base  in  ADDR_WIDTH  first destination address.
REQ-009 len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
REQ-010 busy  out  1  copy in progress.
REQ-011 done  out  1  one-cycle pulse at copy completion.
REQ-012 r_addr  out  ADDR_WIDTH; r_avalid  out  1; r_aready  in  1  read-address handshake.
REQ-013 r_dvalid  in  1; r_data  in  DATA_WIDTH  read response, no backpressure, fixed latency.
REQ-014 w_addr  out  ADDR_WIDTH; w_data  out  DATA_WIDTH; w_valid  out  1; w_ready  in  1  write handshake.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, FINISH.
REQ-016 IDLE: start=1 latches src_base, dst_base, len and moves to RUN. If len=0, it moves to FINISH instead.
REQ-017 While not IDLE, start SHALL be ignored.
REQ-018 Read handshake SHALL be the cycle with r_avalid and r_aready both high.
REQ-019 Once asserted, r_avalid and r_addr SHALL stay stable until the read handshake.
REQ-020 A read SHALL be issued only while reads_issued < len and (outstanding + fifo_count) < FIFO_DEPTH, so every response has a guaranteed slot.
REQ-021 The k-th read address SHALL be (src_base + k) mod 2^ADDR_WIDTH.
REQ-022 outstanding SHALL increment on a read handshake, decrement on r_dvalid, and remain unchanged when both occur in the same cycle.
REQ-023 Each r_dvalid SHALL push r_data into the FIFO in the same cycle.
REQ-024 w_valid SHALL equal RUN and FIFO not empty; w_data SHALL be the FIFO head.
REQ-025 The k-th write address SHALL be (dst_base + k) mod 2^ADDR_WIDTH.
REQ-026 Write handshake (w_valid and w_ready) pops the FIFO. Push and pop in the same cycle SHALL leave the count unchanged.
REQ-027 When the len-th write handshake occurs, the FSM SHALL go RUN -> FINISH.
REQ-028 FINISH: done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-029 busy SHALL be 1 in RUN and FINISH, and 0 in IDLE.
REQ-030 Counters SHALL be ADDR_WIDTH+1 bits wide so that len=2^ADDR_WIDTH completes without overflow.
REQ-031 Write order SHALL equal read-issue order (in-order responses).
REQ-032 A copy SHALL be able to issue a new read in the same cycle an earlier read's response returns.
REQ-033 An r_dvalid received in IDLE SHALL be discarded.

Reset
REQ-034 On rst the FSM SHALL go to IDLE, all counters SHALL clear, and the FIFO SHALL empty.
REQ-035 On rst, busy, done, r_avalid, w_valid, r_addr, w_addr and w_data SHALL all be 0.
REQ-036 Reset mid-copy SHALL abandon the copy with no done pulse. Responses still in flight after reset SHALL be dropped per REQ-033.

Structure
REQ-037 Shared package mem_pkg SHALL hold:
- the state enum (IDLE, RUN, FINISH);
- a width helper for the ADDR_WIDTH+1 count.
REQ-038 The FIFO SHALL be a separate sub-module sync_fifo with parameters WIDTH and DEPTH and push/pop/full/empty/count ports.
REQ-039 The block SHALL connect directly to one requester port of the arbitrated multi-port memory (read latency 2).

Verification
REQ-040 Basic copy: src_base=0, dst_base=8, len=4, grants always high, mem[0..3]=A0..A3 -> mem[8..11]=A0..A3, one done pulse, busy low next cycle.
REQ-041 Wrap-around: src_base=14, dst_base=2, len=4 -> reads 14,15,0,1; writes 2,3,4,5.
REQ-042 Backpressure: w_ready low for 6 cycles mid-copy, len=8:
- r_avalid SHALL drop when outstanding + fifo_count = 4;
- no data is lost; copy completes correctly.
REQ-043 Contention: r_aready toggled 1-of-3 cycles -> r_addr stable while unacknowledged; final contents correct.
REQ-044 len=0 -> done one cycle after start, no r_avalid or w_valid ever asserted.
REQ-045 Reset at cycle 3 of a len=8 copy -> all outputs 0, no done, late r_dvalid ignored. A following len=2 copy completes correctly.
